// File: rtl/tdm_demux_1_to_4.sv
// Receive-side TDM demultiplexer: tracks the slot index of a 4-channel serial stream
// and reassembles each 4-slot frame into one parallel word with a one-cycle valid pulse.
module tdm_demux_1_to_4 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic                 frame_sync,
    output logic [4*WIDTH-1:0]   out_data,
    output logic                 out_valid,
    output logic [1:0]           slot,
    output logic                 locked,
    output logic                 sync_err,
    output logic [CNT_W-1:0]     frame_count
);

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_slot;
    logic [1:0]           w_slot_nxt;
    logic [WIDTH-1:0]     r_shadow     [3];
    logic [WIDTH-1:0]     w_shadow_nxt [3];
    logic [4*WIDTH-1:0]   r_out_data;
    logic [4*WIDTH-1:0]   w_out_data_nxt;
    logic                 r_out_valid;
    logic                 w_out_valid_nxt;
    logic                 r_locked;
    logic                 r_sync_err;
    logic                 w_sync_err_nxt;
    logic [CNT_W-1:0]     r_frame_count;
    logic [CNT_W-1:0]     w_frame_count_nxt;

    // Next-state and datapath decode for one beat; idle cycles only drop the pulses.
    always_comb begin
        w_state_nxt       = r_state;
        w_slot_nxt        = r_slot;
        w_shadow_nxt      = r_shadow;
        w_out_data_nxt    = r_out_data;
        w_out_valid_nxt   = 1'b0;
        w_sync_err_nxt    = 1'b0;
        w_frame_count_nxt = r_frame_count;
        if (din_valid) begin
            case (r_state)
                ST_HUNT: begin
                    if (frame_sync) begin
                        w_shadow_nxt[0] = din;
                        w_slot_nxt      = 2'd1;
                        w_state_nxt     = ST_LOCKED;
                    end else begin
                        w_slot_nxt      = 2'd0;
                    end
                end
                ST_LOCKED: begin
                    // A misplaced sync restarts the frame from this beat as slot 0.
                    if (frame_sync && (r_slot != 2'd0)) begin
                        w_sync_err_nxt  = 1'b1;
                        w_shadow_nxt[0] = din;
                        w_slot_nxt      = 2'd1;
                    end else if (r_slot == 2'd3) begin
                        w_out_data_nxt    = {din, r_shadow[2], r_shadow[1], r_shadow[0]};
                        w_out_valid_nxt   = 1'b1;
                        w_frame_count_nxt = r_frame_count + 1'b1;
                        w_slot_nxt        = 2'd0;
                    end else begin
                        case (r_slot)
                            2'd0:    w_shadow_nxt[0] = din;
                            2'd1:    w_shadow_nxt[1] = din;
                            default: w_shadow_nxt[2] = din;
                        endcase
                        w_slot_nxt = r_slot + 2'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_HUNT;
                    w_slot_nxt  = 2'd0;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_HUNT;
            r_slot        <= 2'd0;
            r_shadow[0]   <= '0;
            r_shadow[1]   <= '0;
            r_shadow[2]   <= '0;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_locked      <= 1'b0;
            r_sync_err    <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_slot        <= w_slot_nxt;
            r_shadow      <= w_shadow_nxt;
            r_out_data    <= w_out_data_nxt;
            r_out_valid   <= w_out_valid_nxt;
            r_locked      <= (w_state_nxt == ST_LOCKED);
            r_sync_err    <= w_sync_err_nxt;
            r_frame_count <= w_frame_count_nxt;
        end
    end

    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign slot        = r_slot;
    assign locked      = r_locked;
    assign sync_err    = r_sync_err;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_tdm_demux_1_to_4.sv
// Bench for tdm_demux_1_to_4: directed and random beats checked against a queue-based
// frame model; a second instance with a 2-bit frame counter checks counter wrap.
module tb_tdm_demux_1_to_4;

    logic       clk;
    logic       rst_n;
    logic       din;
    logic       din_valid;
    logic       frame_sync;
    logic [3:0] out_data,  out_data2;
    logic       out_valid, out_valid2;
    logic [1:0] slot,      slot2;
    logic       locked,    locked2;
    logic       sync_err,  sync_err2;
    logic [7:0] frame_count;
    logic [1:0] frame_count2;

    int total = 0;
    int bad   = 0;

    // Reference model: collected slots of the current partial frame.
    logic       part[$];
    bit         m_locked;
    bit         m_ov;
    bit         m_se;
    logic [3:0] m_data;
    int         m_frames;

    tdm_demux_1_to_4 #(.WIDTH(1), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .frame_sync(frame_sync), .out_data(out_data), .out_valid(out_valid),
        .slot(slot), .locked(locked), .sync_err(sync_err), .frame_count(frame_count)
    );

    tdm_demux_1_to_4 #(.WIDTH(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .frame_sync(frame_sync), .out_data(out_data2), .out_valid(out_valid2),
        .slot(slot2), .locked(locked2), .sync_err(sync_err2), .frame_count(frame_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        part.delete();
        m_locked = 1'b0;
        m_ov     = 1'b0;
        m_se     = 1'b0;
        m_data   = 4'd0;
        m_frames = 0;
    endtask

    task automatic model_edge(input logic v, input logic d, input logic fs);
        m_ov = 1'b0;
        m_se = 1'b0;
        if (v) begin
            if (!m_locked) begin
                if (fs) begin
                    m_locked = 1'b1;
                    part.delete();
                    part.push_back(d);
                end
            end else if (fs && part.size() != 0) begin
                m_se = 1'b1;
                part.delete();
                part.push_back(d);
            end else begin
                part.push_back(d);
                if (part.size() == 4) begin
                    m_data = 4'd0;
                    for (int i = 0; i < 4; i++) m_data[i] = part[i];
                    m_ov = 1'b1;
                    m_frames++;
                    part.delete();
                end
            end
        end
    endtask

    task automatic check_all();
        chk("out_data",     out_data,     m_data);
        chk("out_valid",    out_valid,    m_ov);
        chk("slot",         slot,         part.size());
        chk("locked",       locked,       m_locked);
        chk("sync_err",     sync_err,     m_se);
        chk("frame_count",  frame_count,  m_frames % 256);
        chk("frame_count2", frame_count2, m_frames % 4);
        chk("out_data2",    out_data2,    m_data);
    endtask

    task automatic step(input logic v, input logic d, input logic fs);
        din_valid  = v;
        din        = d;
        frame_sync = fs;
        @(posedge clk);
        model_edge(v, d, fs);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        rst_n      = 1'b0;
        din        = 1'b0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // HUNT discards unsynchronised beats.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        chk("hunt_locked", locked, 32'd0);
        chk("hunt_data", out_data, 32'd0);

        // First frame 1,0,1,1.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("frame1_data", out_data, 32'hD);
        chk("frame1_valid", out_valid, 32'd1);
        step(1'b0, 1'b0, 1'b0);
        chk("frame1_pulse_end", out_valid, 32'd0);

        // Same frame with 3-cycle gaps.
        step(1'b1, 1'b1, 1'b0); idle(3);
        step(1'b1, 1'b0, 1'b0); idle(3);
        step(1'b1, 1'b1, 1'b0); idle(3);
        step(1'b1, 1'b1, 1'b0);
        chk("gap_data", out_data, 32'hD);
        idle(3);

        // Resync at slot 2.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        chk("pre_resync_slot", slot, 32'd2);
        step(1'b1, 1'b0, 1'b1);
        chk("resync_err", sync_err, 32'd1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("resync_data", out_data, 32'h4);

        // Sweep of all 16 frame values, back to back.
        for (int v = 0; v < 16; v++) begin
            logic [3:0] val;
            val = 4'(v);
            for (int s = 0; s < 4; s++) step(1'b1, val[s], (s == 0) ? 1'b1 : 1'b0);
            chk("sweep_data", out_data, val);
        end

        // Asynchronous reset mid-frame at slot 2.
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("post_reset_data", out_data, 32'h7);

        // Random beats.
        for (int i = 0; i < 600; i++) begin
            logic v, d, fs;
            v  = ($urandom_range(0, 3) != 0);
            d  = 1'($urandom_range(0, 1));
            fs = ($urandom_range(0, 7) == 0);
            step(v, d, fs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
